// File: rtl/fp16_pkg.sv
// Shared FP16 format constants and divider FSM state encoding.
// Used by the FP16 divider; the multiplier is to be migrated onto the same constants.
package fp16_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam logic [FP16_EXP_W-1:0] FP16_BIAS    = 5'd15;
    localparam logic [FP16_EXP_W-1:0] FP16_EXP_INF = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        NORM
    } fp16_div_state_e;

endpackage

// File: rtl/fp16_mant_divider.sv
// Restoring mantissa divider: one quotient bit per clock, 12 bits MSB first.
// done is high in the cycle whose closing edge shifts in the final quotient bit.
module fp16_mant_divider
    import fp16_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FP16_FRAC_W:0]   dividend,
    input  logic [FP16_FRAC_W:0]   divisor,
    output logic [FP16_FRAC_W+1:0] quot,
    output logic                   done
);

    logic [11:0] rem_q, rem_d;
    logic [10:0] dvs_q, dvs_d;
    logic [11:0] quot_q, quot_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [12:0] trial;

    always_comb begin
        trial  = {1'b0, rem_q} - {2'b00, dvs_q};
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start) begin
            rem_d  = {1'b0, dividend};
            dvs_d  = divisor;
            quot_d = '0;
            cnt_d  = 4'd11;
            run_d  = 1'b1;
        end else if (run_q) begin
            // R < 2D always holds, so a non-negative trial fits in 11 bits
            if (!trial[12]) begin
                quot_d = {quot_q[10:0], 1'b1};
                rem_d  = {trial[10:0], 1'b0};
            end else begin
                quot_d = {quot_q[10:0], 1'b0};
                rem_d  = {rem_q[10:0], 1'b0};
            end
            if (cnt_q == 4'd0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
        quot_q <= quot_d;
    end

    assign quot = quot_q;
    assign done = run_q && (cnt_q == 4'd0);

endmodule

// File: rtl/fp16_divide.sv
// Iterative FP16 divider (normals only, truncating): FSM, sign/exponent path,
// special-case flags and registered outputs around the mantissa divider.
module fp16_divide
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    input  logic        in_En,
    output logic [15:0] out_Out,
    output logic        out_Ready,
    output logic        out_Busy,
    output logic        out_DivZero
);

    fp16_div_state_e state_q, state_d;

    logic                  start;
    logic                  sign_q, sign_d;
    logic [FP16_EXP_W-1:0] exp_q, exp_d;
    logic                  b_zero_q, b_zero_d;
    logic                  a_zero_q, a_zero_d;
    logic [15:0]           out_q, out_d;
    logic                  dz_q, dz_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [11:0]           quot;
    logic                  mant_done;

    assign start = (state_q == IDLE) && in_En;

    fp16_mant_divider u_mant (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend ({1'b1, in_A[FP16_FRAC_W-1:0]}),
        .divisor  ({1'b1, in_B[FP16_FRAC_W-1:0]}),
        .quot     (quot),
        .done     (mant_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_En) state_d = LOAD;
            LOAD:    state_d = DIV;
            DIV:     if (mant_done) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        b_zero_d = b_zero_q;
        a_zero_d = a_zero_q;
        if (start) begin
            sign_d   = in_A[15] ^ in_B[15];
            exp_d    = in_A[14:10] - in_B[14:10] + FP16_BIAS;
            b_zero_d = (in_B[14:0] == 15'h0000);
            a_zero_d = (in_A[14:10] == 5'h00);
        end
    end

    always_comb begin
        out_d   = out_q;
        dz_d    = dz_q;
        ready_d = 1'b0;
        if (state_q == NORM) begin
            ready_d = 1'b1;
            dz_d    = b_zero_q;
            // Divide-by-zero outranks a zero dividend
            if (b_zero_q) begin
                out_d = {sign_q, FP16_EXP_INF, {FP16_FRAC_W{1'b0}}};
            end else if (a_zero_q) begin
                out_d = {sign_q, 15'h0000};
            end else if (quot[11]) begin
                out_d = {sign_q, exp_q, quot[10:1]};
            end else begin
                out_d = {sign_q, exp_q - 5'd1, quot[9:0]};
            end
        end
        busy_d = (state_d != IDLE) || ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 16'h0000;
            dz_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_q   <= sign_d;
        exp_q    <= exp_d;
        b_zero_q <= b_zero_d;
        a_zero_q <= a_zero_d;
    end

    assign out_Out     = out_q;
    assign out_Ready   = ready_q;
    assign out_Busy    = busy_q;
    assign out_DivZero = dz_q;

endmodule

// File: tb/tb_fp16_divide.sv
// Self-checking bench for fp16_divide: directed cases, handshake timing,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_fp16_divide;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_A = '0;
    logic [15:0] in_B = '0;
    logic        in_En = 1'b0;
    logic [15:0] out_Out;
    logic        out_Ready;
    logic        out_Busy;
    logic        out_DivZero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp16_divide dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_A        (in_A),
        .in_B        (in_B),
        .in_En       (in_En),
        .out_Out     (out_Out),
        .out_Ready   (out_Ready),
        .out_Busy    (out_Busy),
        .out_DivZero (out_DivZero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: {div_zero, result} from the numeric rules using integer division
    function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic       s;
        int         ma, mb, q, e;
        logic [9:0] frac;
        logic [4:0] ef;
        s = a[15] ^ b[15];
        if (b[14:0] == 15'h0) return {1'b1, s, 5'h1F, 10'h000};
        if (a[14:10] == 5'h0) return {1'b0, s, 15'h0};
        ma = 1024 + int'(a[9:0]);
        mb = 1024 + int'(b[9:0]);
        q  = (ma * 2048) / mb;
        e  = int'(a[14:10]) - int'(b[14:10]) + 15;
        if (q >= 2048) begin
            frac = 10'((q / 2) % 1024);
        end else begin
            frac = 10'(q % 1024);
            e    = e - 1;
        end
        ef = e[4:0];
        return {1'b0, s, ef, frac};
    endfunction

    // Runs one divide; optionally pulses in_En at edges k+3 and k+13 to prove they are ignored
    task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b, input bit poke);
        logic [16:0] exp_r;
        int early_rdy;
        int bad_busy;
        int late_rdy;
        exp_r = ref_div(a, b);
        early_rdy = 0;
        bad_busy  = 0;
        late_rdy  = 0;
        @(posedge clk); #1;
        in_A = a; in_B = b; in_En = 1'b1;
        @(posedge clk); #1;
        in_En = 1'b0;
        in_A  = 16'($urandom);
        in_B  = 16'($urandom);
        if (!out_Busy) bad_busy++;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_Ready) early_rdy++;
            if (!out_Busy) bad_busy++;
            in_En = poke && (c == 2 || c == 12);
        end
        @(posedge clk); #1;
        in_En = 1'b0;
        check({tag, " ready_k13"}, 32'(out_Ready), 32'd1);
        check({tag, " busy_k13"}, 32'(out_Busy), 32'd1);
        check({tag, " out"}, 32'(out_Out), 32'(exp_r[15:0]));
        check({tag, " divzero"}, 32'(out_DivZero), 32'(exp_r[16]));
        check({tag, " early_ready"}, 32'(early_rdy), 32'd0);
        check({tag, " busy_gaps"}, 32'(bad_busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " ready_pulse_end"}, 32'(out_Ready), 32'd0);
        check({tag, " busy_end"}, 32'(out_Busy), 32'd0);
        if (poke) begin
            for (int c = 0; c < 16; c++) begin
                @(posedge clk); #1;
                if (out_Ready || out_Busy) late_rdy++;
            end
            check({tag, " ignored_en"}, 32'(late_rdy), 32'd0);
        end
    endtask

    initial begin
        int quiet;
        int cyc;
        int rdy_at[$];
        logic [15:0] ra, rb;

        #12;
        check("reset out", 32'(out_Out), 32'h0);
        check("reset ready", 32'(out_Ready), 32'h0);
        check("reset busy", 32'(out_Busy), 32'h0);
        check("reset dz", 32'(out_DivZero), 32'h0);
        rst_n = 1'b1;

        do_div("6/2", 16'h4600, 16'h4000, 1'b0);
        check("6/2 literal", 32'(out_Out), 32'h4200);
        do_div("1/3", 16'h3C00, 16'h4200, 1'b0);
        check("1/3 literal", 32'(out_Out), 32'h3555);
        do_div("-1.5/0.5", 16'hBE00, 16'h3800, 1'b0);
        check("-1.5/0.5 literal", 32'(out_Out), 32'hC200);
        do_div("0/2", 16'h8000, 16'h4000, 1'b0);
        check("0/2 literal", 32'(out_Out), 32'h8000);
        do_div("2/0", 16'h4000, 16'h0000, 1'b0);
        check("2/0 literal", 32'(out_Out), 32'h7C00);
        check("2/0 dz literal", 32'(out_DivZero), 32'h1);

        // Reset during DIV at edge k+5
        @(posedge clk); #1;
        in_A = 16'h3C00; in_B = 16'h4200; in_En = 1'b1;
        @(posedge clk); #1;
        in_En = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst out", 32'(out_Out), 32'h0);
        check("midrst ready", 32'(out_Ready), 32'h0);
        check("midrst busy", 32'(out_Busy), 32'h0);
        check("midrst dz", 32'(out_DivZero), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_Ready || out_Busy) quiet++;
        end
        check("midrst no_ready", 32'(quiet), 32'd0);
        do_div("after_rst", 16'h3C00, 16'h4200, 1'b0);

        do_div("poke", 16'h4A00, 16'h3E00, 1'b1);

        // in_En held high: results at 13, 27, 41 edges after the first start
        @(posedge clk); #1;
        in_A = 16'h4600; in_B = 16'h4200; in_En = 1'b1;
        cyc = 0;
        quiet = 0;
        while (rdy_at.size() < 3 && cyc < 60) begin
            @(posedge clk); #1;
            if (out_Ready) begin
                rdy_at.push_back(cyc);
                if (out_Out !== ref_div(16'h4600, 16'h4200) >> 0 & 17'h0FFFF) quiet++;
            end
            cyc++;
        end
        in_En = 1'b0;
        check("held pulses", 32'(rdy_at.size()), 32'd3);
        if (rdy_at.size() == 3) begin
            check("held first", 32'(rdy_at[0]), 32'd13);
            check("held gap1", 32'(rdy_at[1] - rdy_at[0]), 32'd14);
            check("held gap2", 32'(rdy_at[2] - rdy_at[1]), 32'd14);
        end
        check("held values", 32'(quiet), 32'd0);
        @(posedge clk); #1;
        check("held busy_end", 32'(out_Busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb[14:0] = 15'h0;
            if ($urandom_range(0, 7) == 0) ra[14:10] = 5'h0;
            do_div($sformatf("rnd%0d", i), ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
